// File: rtl/prod_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prod_acc_pkg
// Description : Shared defaults, state encoding and a clog2 helper for the
//               product accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package prod_acc_pkg;

    // Default geometry: 10x4 multiplier, 9-tap kernel, 16-bit result
    localparam int c_DEF_N   = 10;
    localparam int c_DEF_W   = 4;
    localparam int c_DEF_LEN = 9;
    localparam int c_DEF_OW  = 16;

    // Window state: idle (empty accumulator) or accumulating
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_ACC  = 1'b1;

    // Ceiling log2; clog2(1) == 0
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prod_acc_sat.sv
`default_nettype none
// ============================================================================
// Module      : prod_acc_sat
// Description : Converts the wide accumulator sum to the result width.
//               PROD_ACC_SAT_EN defined   : saturate to the signed OW range.
//               PROD_ACC_SAT_EN undefined : keep the OW LSBs (two's-complement wrap).
// Revision    : 1.0 - initial release
// ============================================================================
module prod_acc_sat #(
    parameter int AW = 17,
    parameter int OW = 16
) (
    input  logic [AW-1:0] i_sum,
    output logic [OW-1:0] o_sum
);

`ifdef PROD_ACC_SAT_EN
    if (AW > OW) begin : g_sat
        localparam logic [OW-1:0] c_MAX = {1'b0, {(OW-1){1'b1}}};
        localparam logic [OW-1:0] c_MIN = {1'b1, {(OW-1){1'b0}}};
        logic w_fits;
        // The value fits when every bit above the OW sign bit copies the sign
        assign w_fits = (i_sum[AW-1:OW-1] == {(AW-OW+1){i_sum[AW-1]}});
        assign o_sum  = w_fits ? i_sum[OW-1:0] : (i_sum[AW-1] ? c_MIN : c_MAX);
    end else begin : g_ext
        assign o_sum = OW'($signed(i_sum));
    end
`else
    if (AW >= OW) begin : g_trunc
        assign o_sum = i_sum[OW-1:0];
        if (AW > OW) begin : g_drop
            // Discarded high bits of the wrapped result
            logic w_unused_hi;
            assign w_unused_hi = ^i_sum[AW-1:OW];
        end
    end else begin : g_ext
        assign o_sum = OW'($signed(i_sum));
    end
`endif

endmodule
`default_nettype wire

// File: rtl/product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : product_accumulator
// Description : Sums LEN signed products per window and presents each window
//               total on a valid/ready output register. Back-to-back windows
//               run without a bubble; only the final term of a window stalls
//               on a full output register.
//               Macro PROD_ACC_SAT_EN selects saturating output conversion
//               (default: two's-complement truncation).
// Revision    : 1.0 - initial release
// ============================================================================
module product_accumulator
    import prod_acc_pkg::*;
#(
    parameter int N   = c_DEF_N,
    parameter int W   = c_DEF_W,
    parameter int LEN = c_DEF_LEN,
    parameter int OW  = c_DEF_OW
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N+W-2:0] i_prod,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic           i_clear,
    output logic [OW-1:0]  o_acc,
    output logic           o_valid,
    input  logic           i_ready
);

    localparam int c_PW = N + W - 1;
    localparam int c_LG = clog2(LEN);
    localparam int c_AW = c_PW + c_LG;
    localparam int c_CW = (c_LG < 1) ? 1 : c_LG;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(LEN - 1);

    state_t                 r_state;
    logic signed [c_AW-1:0] r_acc;
    logic [c_CW-1:0]        r_cnt;

    logic                   w_accept;
    logic                   w_restart;
    logic                   w_last;
    logic signed [c_AW-1:0] w_acc_base;
    logic [c_CW-1:0]        w_cnt_base;
    logic signed [c_AW-1:0] w_term;
    logic signed [c_AW-1:0] w_sum;
    logic [OW-1:0]          w_acc_conv;

    // Only the final term of a window waits for a full output register to drain
    assign o_ready = !((r_cnt == c_LAST) && o_valid && !i_ready);

    // Accept decode; a clear makes the incoming term the first of a new window
    always_comb begin
        w_accept   = i_valid && o_ready;
        w_restart  = i_clear || (r_state == ST_IDLE);
        w_acc_base = w_restart ? '0 : r_acc;
        w_cnt_base = i_clear ? '0 : r_cnt;
        w_last     = (w_cnt_base == c_LAST);
        w_term     = c_AW'($signed(i_prod));
        w_sum      = w_acc_base + w_term;
    end

    prod_acc_sat #(
        .AW (c_AW),
        .OW (OW)
    ) u_sat (
        .i_sum (w_sum),
        .o_sum (w_acc_conv)
    );

    // Window FSM: accumulator, term counter and state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            if (w_last) begin
                r_state <= ST_IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else begin
                r_state <= ST_ACC;
                r_acc   <= w_sum;
                r_cnt   <= w_cnt_base + 1'b1;
            end
        end else if (i_clear) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end
    end

    // Output register: load on window completion, release on handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_acc   <= '0;
            o_valid <= 1'b0;
        end else if (w_accept && w_last) begin
            o_acc   <= w_acc_conv;
            o_valid <= 1'b1;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_product_accumulator
// Description : Directed self-checking bench for product_accumulator at its
//               default geometry (PW=13, AW=17, OW=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_product_accumulator;

    localparam int PW = 13;
    localparam int OW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] i_prod;
    logic          i_valid;
    logic          o_ready;
    logic          i_clear;
    logic [OW-1:0] o_acc;
    logic          o_valid;
    logic          i_ready;

    int errors = 0;
    int checks = 0;
    int exp_sums [3] = '{45, 126, 207};
    int sat_exp;

    always #5 clk = ~clk;

    product_accumulator dut (
        .clk     (clk),
        .rst     (rst),
        .i_prod  (i_prod),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_clear (i_clear),
        .o_acc   (o_acc),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int val, input int n);
        for (int i = 0; i < n; i++) begin
            i_valid = 1'b1;
            i_prod  = PW'(val);
            tick();
        end
        i_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_valid = 1'b0; i_clear = 1'b0; i_ready = 1'b1; i_prod = '0;
        tick();
        tick();
        check("reset_o_valid", 32'(o_valid), 0);
        check("reset_o_acc",   32'($signed(o_acc)), 0);
        check("reset_o_ready", 32'(o_ready), 1);
        rst = 1'b0;
        tick();

        // Nine terms of +5
        send(5, 8);
        check("w5_no_early_valid", 32'(o_valid), 0);
        send(5, 1);
        check("w5_valid", 32'(o_valid), 1);
        check("w5_sum",   32'($signed(o_acc)), 45);
        tick();
        check("w5_valid_one_cycle", 32'(o_valid), 0);

        // Nine terms of -4096: saturate or wrap
`ifdef PROD_ACC_SAT_EN
        sat_exp = -32768;
`else
        sat_exp = 28672;
`endif
        send(-4096, 9);
        check("neg_valid", 32'(o_valid), 1);
        check("neg_sum",   32'($signed(o_acc)), sat_exp);
        tick();

        // Held result while the next window runs
        i_ready = 1'b0;
        send(10, 9);
        check("hold_first_sum", 32'($signed(o_acc)), 90);
        send(2, 8);
        check("hold_ready_low",   32'(o_ready), 0);
        check("hold_sum_stable",  32'($signed(o_acc)), 90);
        i_valid = 1'b1;
        i_prod  = PW'(2);
        tick();
        check("hold_stall_ready", 32'(o_ready), 0);
        check("hold_stall_valid", 32'(o_valid), 1);
        check("hold_stall_sum",   32'($signed(o_acc)), 90);
        i_ready = 1'b1;
        #1;
        check("hold_ready_back", 32'(o_ready), 1);
        tick();
        i_valid = 1'b0;
        check("hold_second_valid", 32'(o_valid), 1);
        check("hold_second_sum",   32'($signed(o_acc)), 18);
        tick();
        check("hold_drained", 32'(o_valid), 0);

        // Reset mid-window discards the partial sum
        send(100, 4);
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(o_valid), 0);
        check("async_rst_acc",   32'($signed(o_acc)), 0);
        check("async_rst_ready", 32'(o_ready), 1);
        tick();
        rst = 1'b0;
        send(1, 9);
        check("post_rst_valid", 32'(o_valid), 1);
        check("post_rst_sum",   32'($signed(o_acc)), 9);

        // Clear with a simultaneous accepted term
        send(100, 3);
        i_clear = 1'b1; i_valid = 1'b1; i_prod = PW'(7);
        tick();
        i_clear = 1'b0; i_valid = 1'b0;
        check("clear_no_output", 32'(o_valid), 0);
        send(1, 8);
        check("clear_acc_valid", 32'(o_valid), 1);
        check("clear_acc_sum",   32'($signed(o_acc)), 15);

        // Clear with no term
        send(50, 2);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        send(3, 9);
        check("clear_only_valid", 32'(o_valid), 1);
        check("clear_only_sum",   32'($signed(o_acc)), 27);

        // Continuous stream 1..27: three back-to-back windows
        for (int k = 1; k <= 27; k++) begin
            i_valid = 1'b1;
            i_prod  = PW'(k);
            tick();
            check($sformatf("stream_valid_%0d", k), 32'(o_valid), 32'((k % 9) == 0));
            if ((k % 9) == 0) begin
                check($sformatf("stream_sum_%0d", k / 9), 32'($signed(o_acc)), exp_sums[k/9-1]);
            end
        end
        i_valid = 1'b0;
        tick();
        check("stream_end_valid", 32'(o_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter N, default 10: multiplicand width feeding the upstream multiplier.
REQ-002 SHALL have parameter W, default 4: multiplier width; product width PW = N+W-1.
REQ-003 SHALL have parameter LEN, default 9: products per accumulation window (kernel taps), LEN >= 1.
REQ-004 SHALL have parameter OW, default 16: result width; internal accumulator width AW = PW + clog2(LEN).
REQ-005 SHALL have port clk  input  1  clock, all flops on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port i_prod  input  PW  signed two's-complement product from the upstream multiplier.
REQ-008 SHALL have port i_valid  input  1  i_prod valid.
REQ-009 SHALL have port o_ready  output  1  block can accept i_prod.
REQ-010 SHALL have port i_clear  input  1  synchronous abort of the current window.
REQ-011 SHALL have port o_acc  output  OW  signed window sum.
REQ-012 SHALL have port o_valid  output  1  o_acc valid.
REQ-013 SHALL have port i_ready  input  1  downstream accepts o_acc.

Function
REQ-014 SHALL accept a term on a cycle with i_valid && o_ready.
REQ-015 SHALL sign-extend i_prod to AW and add it to the accumulator; the AW-bit sum never overflows.
REQ-016 SHALL count accepted terms 0..LEN-1 and wrap to 0 on the LEN-th accept.
REQ-017 SHALL use states ST_IDLE (cnt==0, acc==0) and ST_ACC (0<cnt<LEN); ST_IDLE->ST_ACC on accept; ST_ACC->ST_IDLE on the LEN-th accept or i_clear. LEN==1 stays in ST_IDLE.
REQ-018 SHALL load the completed sum (acc + final term) into the output register on the LEN-th accept, assert o_valid the next cycle, and clear acc in the same cycle, so back-to-back windows run without a bubble.
REQ-019 SHALL hold o_acc/o_valid stable until o_valid && i_ready, then drop o_valid unless a new result loads in the same cycle.
REQ-020 SHALL drive o_ready = !(cnt==LEN-1 && o_valid && !i_ready): only the final term stalls on a full output register.
REQ-021 SHALL, on i_clear without accept, zero acc and cnt. On i_clear with a simultaneous accept, set acc = that term and cnt = 1. i_clear leaves the output register untouched.
REQ-022 SHALL convert the AW-bit sum to OW bits per REQ-025/026 at the output-register load.

Reset
REQ-023 SHALL, on rst, immediately clear acc, cnt, state=ST_IDLE, o_acc=0, o_valid=0; o_ready=1 after reset.
REQ-024 SHALL discard a partial window interrupted by reset; the first post-reset window starts from zero.

Configuration
REQ-025 SHALL, with PROD_ACC_SAT_EN defined, saturate the sum to [-2^(OW-1), 2^(OW-1)-1].
REQ-026 SHALL, without PROD_ACC_SAT_EN, truncate the sum to its OW LSBs (two's-complement wrap).

Structure
REQ-027 SHALL place the state typedef, the clog2 function and the default N/W/LEN/OW in package prod_acc_pkg.
REQ-028 SHALL implement the REQ-025/026 conversion in sub-module prod_acc_sat (AW in, OW out, macro-controlled).

Verification (defaults: PW=13, AW=17, OW=16)
REQ-029 SHALL cover: 9 terms of +5, i_ready=1 -> o_acc=45, o_valid high for exactly 1 cycle, one cycle after the 9th accept.
REQ-030 SHALL cover: 9 terms of -4096 -> o_acc=-32768 with PROD_ACC_SAT_EN, 28672 without.
REQ-031 SHALL cover: i_ready=0 holding a result while the next window runs -> 8 terms accepted, o_ready=0 at the 9th; when i_ready is raised, o_ready returns and the second sum appears next cycle.
REQ-032 SHALL cover: rst asserted after 4 terms of 100, then 9 terms of 1 -> o_acc=9.
REQ-033 SHALL cover: 3 terms of 100, then i_clear with an accepted term 7, then 8 terms of 1 -> o_acc=15.
REQ-034 SHALL cover: continuous i_valid of 27 terms, values 1..27, i_ready=1 -> o_valid every 9 cycles with sums 45, 126, 207.
